// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle ALU:
//   - 4-bit opcode constants (OP_ADD .. OP_MULH; 0xC-0xF are reserved)
//   - FSM state enum (IDLE / BUSY / DONE)
//   - packed flag register layout
//   - helpers to classify opcodes
// -----------------------------------------------------------------------------
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBB  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_MULH = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic c;   // carry / borrow
        logic z;   // result == 0
        logic gt;  // a > b (unsigned), last CMP
        logic eq;  // a == b, last CMP
    } flags_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

    function automatic logic is_reserved(input logic [3:0] op);
        return op > OP_MULH;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Operation / result bus of the multi-cycle ALU.
//   Request side : in_valid, in_ready, opcode[3:0], a, b
//   Response side: out_valid, out_ready, result, flag_c, flag_z, flag_gt, flag_eq
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer holds valid and its payload stable until that
// edge; ready may be raised or lowered freely and never depends on a future
// transfer. While out_valid is high and out_ready low, result and all flags
// are held stable.
//
// Modports: master = decode/writeback side, slave = ALU.
// -----------------------------------------------------------------------------
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_gt;
    logic             flag_eq;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_gt, flag_eq
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_gt, flag_eq
    );
endinterface

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   start_i         load a_i, b_i and begin (ignored-safe: restarts if busy)
//   a_i, b_i        WIDTH-bit unsigned operands
//   busy_o          iterations in progress
//   done_o          high during the final iteration cycle
//   product_o       2*WIDTH-bit product, valid while done_o is high
// After start at edge k, edges k+1..k+WIDTH consume b[0]..b[WIDTH-1].
// product_o is the accumulator value being written by the current iteration,
// so the consumer can capture the finished product at edge k+WIDTH itself.
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_d;
    logic               last_iter;

    always_comb begin
        partial   = mplier_q[0] ? mcand_q : '0;
        acc_d     = acc_q + partial;
        // cnt_q counts completed iterations; this one brings it to WIDTH
        last_iter = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_iter) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = last_iter;
    assign product_o = acc_d;

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with registered result, persistent flags (for ADC/SBB
// chaining) and an iterative multiplier.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   bus          alu_mc_if.slave: operation request and result response
//   state_o      current FSM state, for observation
// Single-cycle ops complete one edge after accept; MUL/MULH take WIDTH edges.
// Result and flags are written on the edge that enters DONE, so an ADC/SBB
// accepted back-to-back from DONE sees the carry of the op just completed.
// -----------------------------------------------------------------------------
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_mc_if.slave bus,
    output state_e state_o
);

    localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             mulh_q, mulh_d;

    logic             in_ready;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] mul_res;

    logic [WIDTH-1:0] sc_result;
    flags_t           sc_flags;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             cin_add;
    logic             cin_sub;
    logic             shift_big;

    // in_ready is forced low while reset is held
    assign in_ready = rst_n && ((state_q == ST_IDLE) ||
                                (state_q == ST_DONE && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        sc_result = '0;
        sc_flags  = flags_q;
        cin_add   = (bus.opcode == OP_ADC) && flags_q.c;
        cin_sub   = (bus.opcode == OP_SBB) && flags_q.c;
        sum       = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH + 1)'(cin_add);
        // top bit of the (WIDTH+1)-bit difference is the borrow
        diff      = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH + 1)'(cin_sub);
        shift_big = {1'b0, bus.b} >= WIDTH_V;

        case (bus.opcode)
            OP_ADD, OP_ADC: begin
                sc_result  = sum[WIDTH-1:0];
                sc_flags.c = sum[WIDTH];
            end
            OP_SUB, OP_SBB: begin
                sc_result  = diff[WIDTH-1:0];
                sc_flags.c = diff[WIDTH];
            end
            OP_AND: sc_result = bus.a & bus.b;
            OP_OR:  sc_result = bus.a | bus.b;
            OP_XOR: sc_result = bus.a ^ bus.b;
            OP_CMP: begin
                sc_result   = '0;
                sc_flags.gt = bus.a > bus.b;
                sc_flags.eq = bus.a == bus.b;
            end
            OP_SHL: sc_result = shift_big ? '0 : (bus.a << bus.b);
            OP_SHR: sc_result = shift_big ? '0 : (bus.a >> bus.b);
            default: sc_result = '0;
        endcase

        if (bus.opcode != OP_CMP && !is_reserved(bus.opcode)) begin
            sc_flags.z = (sc_result == '0);
        end
    end

    // ---------------- multiplier ----------------
    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign mul_res = mulh_q ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];

    // ---------------- FSM next state / register updates ----------------
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        mulh_d    = mulh_q;
        mul_start = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                if (mul_busy && mul_done) begin
                    state_d   = ST_DONE;
                    result_d  = mul_res;
                    flags_d.z = (mul_res == '0);
                end
            end
            ST_DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // accept only happens in IDLE or DONE, never alongside the BUSY branch
        if (accept) begin
            if (is_mul(bus.opcode)) begin
                mul_start = 1'b1;
                mulh_d    = (bus.opcode == OP_MULH);
                state_d   = ST_BUSY;
            end else begin
                result_d = sc_result;
                flags_d  = sc_flags;
                state_d  = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            mulh_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mulh_q   <= mulh_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_gt   = flags_q.gt;
    assign bus.flag_eq   = flags_q.eq;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc (WIDTH=8). Issued operations are evaluated
// by an arithmetic reference model and pushed to exp_q; a monitor pops and
// compares on every result handshake. Directed checks cover reset, latency,
// back-pressure, BUSY blocking and reset during a multiply.
// -----------------------------------------------------------------------------
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    state_e dbg_state;

    alu_mc #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    logic rand_ready = 1'b0;
    logic rnd_ready  = 1'b1;
    logic man_ready  = 1'b1;
    assign bus.out_ready = rand_ready ? rnd_ready : man_ready;

    always @(posedge clk) begin
        if (rand_ready) begin
            #2 rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W+3:0] exp_q[$];
    logic [W+3:0] mon_got;
    logic [W+3:0] mon_exp;

    // reference flag state
    logic m_c = 1'b0, m_z = 1'b0, m_gt = 1'b0, m_eq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W+3:0] e);
        int unsigned ai, bi, cin, full, r, sub;
        ai   = a;
        bi   = b;
        cin  = m_c;
        full = 1 << W;
        r    = 0;
        case (op)
            OP_ADD, OP_ADC: begin
                r   = ai + bi + ((op == OP_ADC) ? cin : 0);
                m_c = (r >= full);
                r   = r % full;
            end
            OP_SUB, OP_SBB: begin
                sub = bi + ((op == OP_SBB) ? cin : 0);
                m_c = (ai < sub);
                r   = (ai + full - sub) % full;
            end
            OP_AND: r = ai & bi;
            OP_OR:  r = ai | bi;
            OP_XOR: r = ai ^ bi;
            OP_CMP: begin
                r    = 0;
                m_gt = (ai > bi);
                m_eq = (ai == bi);
            end
            OP_SHL:  r = (bi >= W) ? 0 : (ai * (1 << bi)) % full;
            OP_SHR:  r = (bi >= W) ? 0 : ai / (1 << bi);
            OP_MUL:  r = (ai * bi) % full;
            OP_MULH: r = (ai * bi) / full;
            default: r = 0;
        endcase
        if (op <= OP_MULH && op != OP_CMP) m_z = (r == 0);
        e = {W'(r), m_c, m_z, m_gt, m_eq};
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.result, bus.flag_c, bus.flag_z, bus.flag_gt, bus.flag_eq};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL result_flags: got {res,c,z,gt,eq}=0x%0h expected 0x%0h",
                             mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+3:0] e;
        bit acc;
        int guard;
        model(op, a, b, e);
        exp_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of op 0x%0h", op);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    int   lat;
    time  t0;
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;

    initial begin
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.a        = '0;
        bus.b        = '0;

        // reset
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.flag_c, bus.flag_z, bus.flag_gt, bus.flag_eq}, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // add / adc chain
        issue(OP_ADD, 8'hF0, 8'h20);
        drain();
        check("add_result", bus.result, 8'h10);
        check("add_c", bus.flag_c, 1);
        check("add_z", bus.flag_z, 0);
        issue(OP_ADC, 8'h00, 8'h00);
        drain();
        check("adc_result", bus.result, 8'h01);
        check("adc_c", bus.flag_c, 0);

        // sub / sbb
        issue(OP_SUB, 8'h05, 8'h05);
        drain();
        check("sub_eq_result", bus.result, 8'h00);
        check("sub_eq_z", bus.flag_z, 1);
        check("sub_eq_c", bus.flag_c, 0);
        issue(OP_SBB, 8'h00, 8'h00);
        issue(OP_SUB, 8'h03, 8'h04);
        drain();
        check("sub_borrow_result", bus.result, 8'hFF);
        check("sub_borrow_c", bus.flag_c, 1);

        // cmp / shifts
        issue(OP_CMP, 8'h80, 8'h7F);
        drain();
        check("cmp_gt", bus.flag_gt, 1);
        check("cmp_eq", bus.flag_eq, 0);
        check("cmp_c_held", bus.flag_c, 1);
        issue(OP_SHL, 8'h81, 8'd1);
        drain();
        check("shl_result", bus.result, 8'h02);
        issue(OP_SHR, 8'h81, 8'd8);
        drain();
        check("shr_big_result", bus.result, 8'h00);
        check("shr_big_z", bus.flag_z, 1);

        // multiply latency, BUSY blocks accept
        issue(OP_MUL, 8'hFF, 8'hFF);
        lat = 20;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 2) begin
                bus.in_valid = 1'b1;
                bus.opcode   = OP_ADD;
                bus.a        = 8'h11;
                bus.b        = 8'h22;
                check("busy_in_ready", bus.in_ready, 0);
            end
            if (cyc == 3) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat = cyc;
                break;
            end
        end
        check("mul_latency", lat, W);
        drain();
        check("mul_result", bus.result, 8'h01);
        issue(OP_MULH, 8'hFF, 8'hFF);
        drain();
        check("mulh_result", bus.result, 8'hFE);

        // throughput: back-to-back single-cycle ops
        t0 = $time;
        for (int i = 0; i < 4; i++) issue(OP_ADD, 8'(i), 8'h01);
        check("throughput_cycles", 32'(($time - t0) / 10), 4);
        drain();

        // back-pressure
        man_ready = 1'b0;
        issue(OP_ADD, 8'h12, 8'h34);
        fork
            issue(OP_SUB, 8'h50, 8'h10);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_out_valid", bus.out_valid, 1);
                    check("bp_in_ready", bus.in_ready, 0);
                    check("bp_result", bus.result, 8'h46);
                end
                @(posedge clk);
                #1 man_ready = 1'b1;
            end
        join
        drain();
        check("bp_next_result", bus.result, 8'h40);

        // reset during multiply
        issue(OP_CMP, 8'h80, 8'h7F);
        issue(OP_ADD, 8'hF0, 8'h20);
        drain();
        issue(OP_MUL, 8'h0F, 8'h0F);
        idle_cycles(2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_flags", {bus.flag_c, bus.flag_z, bus.flag_gt, bus.flag_eq}, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        m_c = 1'b0; m_z = 1'b0; m_gt = 1'b0; m_eq = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_ready", bus.in_ready, 1);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        issue(OP_ADC, 8'h01, 8'h01);
        drain();

        // randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, W + 1)) : 8'($urandom);
            issue(rop, ra, rb);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        rand_ready = 1'b0;
        man_ready  = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
